dco_trim_controller: RTL

Frequency-locking controller that closes the loop around the 13-stage trimmable ring oscillator. It runs on the oscillator's own output clock and counts oscillator cycles per period of an asynchronous reference. It then steps a 0..26 trim code up or down until the count matches a programmed divider, and drives the oscillator's 26-bit trim vector. A lock flag reports a stable frequency match.

---
 rtl/dco_trim_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dco_trim_controller.sv
// dco_trim_controller
//   Frequency-locking loop for the 13-stage trimmable ring oscillator. Runs on
//   the oscillator's own clock, counts oscillator cycles per period of an
//   asynchronous reference, and steps a 0..26 trim code one unit per reference
//   period until the count matches `div`. Drives a 26-bit thermometer trim.
//
//   Ports:
//     clock   in   oscillator output clock, all flops on posedge
//     resetb  in   asynchronous active-low reset
//     enable  in   loop enable (synchronous to clock)
//     osc     in   reference clock (asynchronous to clock)
//     div     in   target oscillator cycles per reference period (quasi-static)
//     trim    out  thermometer trim, bit k set for k < tval
//     tval    out  current trim code 0..26
//     lock    out  frequency locked (LOCK_CNT consecutive in-band results)
module dco_trim_controller #(
    parameter int DIV_W     = 7,
    parameter int CNT_W     = 8,
    parameter int TRIM_INIT = 13,
    parameter int DEADBAND  = 0,
    parameter int LOCK_CNT  = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [DIV_W-1:0] div,
    output logic [25:0]      trim,
    output logic [4:0]       tval,
    output logic             lock
);

    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam logic [LK_W-1:0]      LK_MAX   = LK_W'(LOCK_CNT);
    localparam logic [LK_W-1:0]      LK_ONE   = LK_W'(1);
    localparam logic [4:0]           TVAL_MAX = 5'd26;
    localparam logic [4:0]           TVAL_RST = 5'(TRIM_INIT);
    // One extra bit so TRIM_INIT = 26 still yields all-ones after the subtract.
    localparam logic [26:0]          TRIM_RST = (27'd1 << TRIM_INIT) - 27'd1;
    localparam logic signed [CNT_W:0] DB_POS  = (CNT_W+1)'(DEADBAND);
    localparam logic signed [CNT_W:0] DB_NEG  = -DB_POS;

    logic             s1_q, s2_q, s3_q;
    logic             s1_d, s2_d, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             valid_q, valid_d;
    logic             upd_q, upd_d;
    logic [4:0]       tval_q, tval_d;
    logic [LK_W-1:0]  lk_q, lk_d;
    logic             lock_q, lock_d;
    logic [25:0]      trim_q, trim_d;

    logic                    ref_edge;
    logic signed [CNT_W:0]   diff;

    always_comb begin
        s1_d     = osc;
        s2_d     = s1_q;
        s3_d     = s2_q;
        ref_edge = s2_q & ~s3_q;

        cnt_d   = cnt_q;
        meas_d  = meas_q;
        valid_d = valid_q;
        upd_d   = 1'b0;

        if (!enable) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (ref_edge) begin
            meas_d  = cnt_q;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            valid_d = 1'b1;
            // The first edge after (re)start only arms the loop.
            upd_d   = valid_q;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        diff = $signed({1'b0, meas_q}) - $signed({{(CNT_W+1-DIV_W){1'b0}}, div});

        tval_d = tval_q;
        lk_d   = lk_q;
        if (!enable || (div == '0)) begin
            lk_d = '0;
        end else if (upd_q) begin
            if (diff > DB_POS) begin
                // Too many oscillator cycles: slow it down with more trim.
                lk_d = '0;
                if (tval_q != TVAL_MAX) tval_d = tval_q + 5'd1;
            end else if (diff < DB_NEG) begin
                lk_d = '0;
                if (tval_q != 5'd0) tval_d = tval_q - 5'd1;
            end else if (lk_q != LK_MAX) begin
                lk_d = lk_q + LK_ONE;
            end
        end
        // Registered from lk_d so lock moves in the same cycle as tval.
        lock_d = (lk_d == LK_MAX);

        trim_d = '0;
        for (int k = 0; k < 26; k++) begin
            trim_d[k] = (5'(k) < tval_q);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            meas_q  <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            tval_q  <= TVAL_RST;
            lk_q    <= '0;
            lock_q  <= 1'b0;
            trim_q  <= TRIM_RST[25:0];
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            tval_q  <= tval_d;
            lk_q    <= lk_d;
            lock_q  <= lock_d;
            trim_q  <= trim_d;
        end
    end

    assign trim = trim_q;
    assign tval = tval_q;
    assign lock = lock_q;

endmodule
